// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: processor bus widths,
// responder FSM state encoding and the request-type encoding.
package mem_responder_pkg;

    localparam int PROC_DATA_WIDTH = 32;
    localparam int PROC_ADDR_WIDTH = 26;
    localparam int RESP_ADDR_WIDTH = 10;
    localparam int RESP_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_DONE = 2'd2,
        RESP_HOLD = 2'd3
    } resp_state_e;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    // Value loaded into the wait counter when a request is captured.
    function automatic logic [RESP_CNT_WIDTH-1:0] wait_load(input int latency);
        if (latency > 0) begin
            return RESP_CNT_WIDTH'(latency - 1);
        end else begin
            return {RESP_CNT_WIDTH{1'b0}};
        end
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous storage with registered read data.
// Only the read register is reset; the word array keeps its contents.
module mem_resp_array
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = PROC_DATA_WIDTH,
    parameter int ADDR_WIDTH = RESP_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Word write port.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: holds the last word read until the next read or reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures level-held READ/WRITE requests, inserts
// LATENCY wait cycles, then completes with an ACK held until the request drops.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = PROC_DATA_WIDTH,
    parameter int ADDR_WIDTH = RESP_ADDR_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       READ,
    input  logic                       WRITE,
    input  logic [PROC_ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0]      DATA_IN,
    output logic [DATA_WIDTH-1:0]      DATA_OUT,
    output logic                       ACK,
    output logic                       BUSY,
    output logic                       ERR
);

    localparam logic [RESP_CNT_WIDTH-1:0] LAT_LOAD = wait_load(LATENCY);

    resp_state_e               r_state;
    req_type_e                 r_type;
    logic [RESP_CNT_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_ack;
    logic                      r_busy;
    logic                      r_err;

    logic w_req_line;
    logic w_we;
    logic w_re;
    logic w_unused_addr_hi;

    // Upper address bits are not decoded, giving modulo-depth aliasing.
    assign w_unused_addr_hi = ^ADDR[PROC_ADDR_WIDTH-1:ADDR_WIDTH];

    // Track only the strobe matching the latched request type.
    always_comb begin
        if (r_type == REQ_READ) begin
            w_req_line = READ;
        end else begin
            w_req_line = WRITE;
        end
    end

    assign w_we = (r_state == RESP_DONE) && (r_type == REQ_WRITE);
    assign w_re = (r_state == RESP_DONE) && (r_type == REQ_READ);

    // Request FSM with registered handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= RESP_IDLE;
            r_type  <= REQ_READ;
            r_cnt   <= {RESP_CNT_WIDTH{1'b0}};
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                RESP_IDLE: begin
                    if (READ && WRITE) begin
                        r_err <= 1'b1;
                    end else if (READ || WRITE) begin
                        r_type  <= WRITE ? REQ_WRITE : REQ_READ;
                        r_addr  <= ADDR[ADDR_WIDTH-1:0];
                        r_wdata <= DATA_IN;
                        r_busy  <= 1'b1;
                        r_cnt   <= LAT_LOAD;
                        if (LATENCY == 0) begin
                            r_state <= RESP_DONE;
                        end else begin
                            r_state <= RESP_WAIT;
                        end
                    end
                end
                RESP_WAIT: begin
                    // A dropped request abandons the access before any storage effect.
                    if (!w_req_line) begin
                        r_state <= RESP_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == {RESP_CNT_WIDTH{1'b0}}) begin
                        r_state <= RESP_DONE;
                    end else begin
                        r_cnt <= r_cnt - {{(RESP_CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                RESP_DONE: begin
                    r_ack   <= 1'b1;
                    r_state <= RESP_HOLD;
                end
                RESP_HOLD: begin
                    if (!w_req_line) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= RESP_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= RESP_IDLE;
                end
            endcase
        end
    end

    mem_resp_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .CLK    (CLK),
        .RST    (RST),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (r_addr),
        .i_wdata(r_wdata),
        .o_rdata(DATA_OUT)
    );

    assign ACK  = r_ack;
    assign BUSY = r_busy;
    assign ERR  = r_err;

endmodule
